fwd_source_pipe: RTL

- EX->MEM->WB result pipeline that produces the forwarding sources consumed by the operand forwarding mux: MEM-stage value/rd/enable and WB-stage value/rd/enable.
- Detects load-use hazards the mux cannot resolve, because a MEM-stage load holds an address, not data.
- On a load-use hazard, inserts a MEM bubble so the load reaches WB before the consumer proceeds.
- Counts stall cycles for performance monitoring.

---
 rtl/fwd_source_pipe_pkg.sv | 16 +
 rtl/fwd_source_pipe_sat_counter.sv | 33 +++
 rtl/fwd_source_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/fwd_source_pipe_pkg.sv
// Shared widths and the pipeline stage record for the forwarding-source pipe.
package fwd_source_pipe_pkg;

  localparam int DBITS_DEFAULT   = 32;
  localparam int REG_IDX_DEFAULT = 4;
  localparam int CNT_DEFAULT     = 32;

  typedef struct packed {
    logic                       valid;
    logic [DBITS_DEFAULT-1:0]   data;
    logic [REG_IDX_DEFAULT-1:0] rd;
    logic                       wrt_en;
    logic                       is_load;
  } stage_t;

endpackage

// File: rtl/fwd_source_pipe_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fwd_source_pipe.sv
// EX->MEM->WB result pipe feeding the operand forwarding mux; stalls one cycle
// when the consumer needs a value that is still a load address in MEM.
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
#(
  parameter int DBITS               = DBITS_DEFAULT,
  parameter int REG_INDEX_BIT_WIDTH = REG_IDX_DEFAULT,
  parameter int CNT_BITS            = CNT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           exValid,
  input  logic [DBITS-1:0]               exResult,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] exRd,
  input  logic                           exWrtEn,
  input  logic                           exIsLoad,
  input  logic                           flush,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] idRs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] idRs2,
  input  logic                           idRs1Used,
  input  logic                           idRs2Used,
  input  logic [DBITS-1:0]               dmemRdata,
  output logic [DBITS-1:0]               memData,
  output logic [REG_INDEX_BIT_WIDTH-1:0] memRd,
  output logic                           memWrtEn,
  output logic                           memIsLoad,
  output logic [DBITS-1:0]               wbData,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wbRd,
  output logic                           wbWrtEn,
  output logic                           loadUseStall,
  output logic [CNT_BITS-1:0]            stallCount
);

  // Same layout as the package stage record, but sized by this instance's parameters.
  typedef struct packed {
    logic                           valid;
    logic [DBITS-1:0]               data;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd;
    logic                           wrt_en;
    logic                           is_load;
  } mem_rec_t;

  mem_rec_t                       mem_q;
  mem_rec_t                       mem_d;
  logic [DBITS-1:0]               wb_data_q;
  logic [DBITS-1:0]               wb_data_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd_q;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd_d;
  logic                           wb_wrt_en_q;
  logic                           wb_wrt_en_d;
  logic                           load_use_stall;
  logic                           rs1_hit;
  logic                           rs2_hit;

  // A load in MEM only carries an address, so a matching consumer must wait.
  always_comb begin
    rs1_hit        = idRs1Used && (idRs1 == mem_q.rd);
    rs2_hit        = idRs2Used && (idRs2 == mem_q.rd);
    load_use_stall = mem_q.valid && mem_q.is_load && mem_q.wrt_en && (rs1_hit || rs2_hit);
  end

  always_comb begin
    mem_d = '0;
    if (!(load_use_stall || flush)) begin
      mem_d.valid   = exValid;
      mem_d.data    = exResult;
      mem_d.rd      = exRd;
      mem_d.wrt_en  = exWrtEn;
      mem_d.is_load = exIsLoad;
    end
  end

  always_comb begin
    wb_wrt_en_d = mem_q.valid && mem_q.wrt_en;
    wb_rd_d     = mem_q.rd;
    wb_data_d   = mem_q.is_load ? dmemRdata : mem_q.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q       <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_wrt_en_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_wrt_en_q <= wb_wrt_en_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_BITS)
  ) u_stall_counter (
    .clk    (clk),
    .reset  (reset),
    .inc_en (load_use_stall),
    .count  (stallCount)
  );

  assign memData      = mem_q.data;
  assign memRd        = mem_q.rd;
  assign memWrtEn     = mem_q.valid && mem_q.wrt_en && !mem_q.is_load;
  assign memIsLoad    = mem_q.valid && mem_q.is_load;
  assign wbData       = wb_data_q;
  assign wbRd         = wb_rd_q;
  assign wbWrtEn      = wb_wrt_en_q;
  assign loadUseStall = load_use_stall;

endmodule
